cell_refcnt_free: RTL
=====================

Name: cell_refcnt_free

Overview:
- Sits directly downstream of the cell allocator.
- Records a per-cell multicast reference count when a cell is written into the shared buffer.
- Collects per-output-port cell release requests and decrements the count for each one.
- When a count reaches zero, pushes the cell address into a first-word-fall-through free-address FIFO and pulses a free flag. The FIFO and flag feed the allocator's hmp_rd/hmp_valid/hmp_addr/bf_free_flag interface.

Parameters:
- MWIDTH, 4, number of output ports (multicast vector width)
- AWIDTH, 7, cell address width; buffer holds 2**AWIDTH cells

Ports:
- clk  input  1  single clock; all logic on rising edge
- clr  input  1  reset, synchronous, active-high
- i_gsm_wr_en  input  1  allocator wrote a cell this cycle
- i_gsm_cell_addr  input  AWIDTH  address of written cell
- i_gsm_multicast  input  MWIDTH  destination ports of written cell
- i_rel_valid  input  MWIDTH  per-port release request; held until granted
- i_rel_addr  input  MWIDTH*AWIDTH  per-port released address; port p in bits [p*AWIDTH +: AWIDTH]
- o_rel_gnt  output  MWIDTH  one-hot grant, combinational, same cycle as request
- i_hmp_rd  input  1  pop free FIFO head
- o_hmp_valid  output  1  free FIFO not empty
- o_hmp_addr  output  AWIDTH  free FIFO head (FWFT, valid when o_hmp_valid)
- o_bf_free_flag  output  1  one-cycle pulse per address pushed to free FIFO
- o_free_cnt  output  AWIDTH+1  FIFO occupancy
- o_err  output  1  sticky protocol error

Behaviour:
- Reset (clr high at an edge):
  - all refcounts = 0
  - FIFO empty; o_hmp_valid = 0, o_free_cnt = 0, o_hmp_addr = 0
  - o_bf_free_flag = 0, o_err = 0
  - round-robin pointer = port 0
  - clr mid-operation discards all in-flight state; o_rel_gnt = 0 while clr is high
- Reset does not prefill the FIFO: the allocator's own init counter covers the first 2**AWIDTH allocations.
- Refcount array:
  - 2**AWIDTH entries × CNT_W = clogb(MWIDTH)+1 bits, flop-based register file
  - one allocation write port, one release read-modify-write port
- Allocation: when i_gsm_wr_en, the entry at i_gsm_cell_addr is set to popcount(i_gsm_multicast) at the edge.
  - Target entry already nonzero -> o_err set; entry still overwritten.
  - Popcount 0 -> o_err set.
- Release arbitration:
  - round-robin among i_rel_valid bits, at most one grant per cycle
  - search starts at pointer; after a grant, pointer = granted port + 1 mod MWIDTH
  - no request -> pointer unchanged
- Release in the grant cycle N (single-cycle read-modify-write):
  - read count of the granted address combinationally
  - count > 1: write count-1 at edge end of N
  - count == 1: write 0, push address to FIFO at the same edge, o_bf_free_flag = 1 during cycle N+1, o_hmp_valid = 1 from N+1
  - count == 0 (double free): o_err set; no write, no push, grant still issued (request consumed)
- Allocation and release to the same address in the same cycle is a protocol violation: o_err set, allocation write wins.
- Free FIFO:
  - depth 2**AWIDTH, count AWIDTH+1 bits, pointers wrap mod 2**AWIDTH
  - i_hmp_rd pops at the edge when o_hmp_valid; o_hmp_addr shows the new head next cycle
  - i_hmp_rd while empty -> o_err set, ignored
  - push and pop in the same cycle -> count unchanged
  - push to empty with pop the same cycle -> pop is ignored and flagged
  - push while count == 2**AWIDTH -> o_err set, push dropped; unreachable under a correct protocol
- o_bf_free_flag is registered and never asserted for a dropped push.
- o_err stays high until clr.

Decomposition:
- Shared package/header holds:
  - clogb function (existing c_functions header)
  - CNT_W = clogb(MWIDTH)+1
  - DEPTH = 2**AWIDTH
- One sub-module, rr_arbiter (MWIDTH requests, one-hot grant, internal pointer, synchronous clr).
- The free FIFO stays inline; its logic is small.

Test Plan:
- Reset then idle -> o_hmp_valid=0, o_free_cnt=0, o_bf_free_flag=0, o_err=0.
- Alloc addr 5 with multicast 4'b1011 (count 3); release 5 from ports 0, 1, 3 on separate cycles -> first two releases produce no flag; third gives o_bf_free_flag in the next cycle, o_hmp_addr=5, o_free_cnt=1.
- Ports 0-3 all request simultaneously, each holding until granted -> grants in order 0, 1, 2, 3 over 4 cycles; with only ports 1 and 3 requesting continuously, grants alternate 1, 3, 1, 3.
- Free 128 distinct single-destination cells, then pop all with i_hmp_rd -> addresses come out in push order, o_free_cnt goes 128 then 0, pointer wrap is correct, o_err=0.
- Release addr 9 while its count is 0 -> o_err=1 and stays high; no push.
- Push and pop in the same cycle at count 3 -> count stays 3. Assert clr mid-stream -> next cycle o_hmp_valid=0 and all counts cleared.

Source files
------------

// File: rtl/cell_refcnt_free_pkg.sv
// Shared helpers and default sizing for the cell reference-count / free-address block.
package cell_refcnt_free_pkg;

  // Ceiling log2; clogb(1) = 0.
  function automatic int clogb(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  function automatic int popcount(input logic [31:0] v);
    int n;
    n = 0;
    for (int i = 0; i < 32; i++) begin
      if (v[i]) n = n + 1;
    end
    return n;
  endfunction

  localparam int MWIDTH_DEF = 4;
  localparam int AWIDTH_DEF = 7;
  localparam int CNT_W      = clogb(MWIDTH_DEF) + 1;
  localparam int DEPTH      = 2 ** AWIDTH_DEF;

  typedef enum logic [1:0] {
    REL_NONE = 2'd0,
    REL_DEC  = 2'd1,
    REL_FREE = 2'd2,
    REL_ERR  = 2'd3
  } rel_op_e;

endpackage

// File: rtl/cell_refcnt_free_if.sv
// Allocator-side bus of cell_refcnt_free: allocation write, port releases and free-address FIFO.
interface cell_refcnt_free_if import cell_refcnt_free_pkg::*; #(
  parameter int MWIDTH = MWIDTH_DEF,
  parameter int AWIDTH = AWIDTH_DEF
);
  logic                       i_gsm_wr_en;
  logic [AWIDTH-1:0]          i_gsm_cell_addr;
  logic [MWIDTH-1:0]          i_gsm_multicast;
  logic [MWIDTH-1:0]          i_rel_valid;
  logic [MWIDTH*AWIDTH-1:0]   i_rel_addr;
  logic [MWIDTH-1:0]          o_rel_gnt;
  logic                       i_hmp_rd;
  logic                       o_hmp_valid;
  logic [AWIDTH-1:0]          o_hmp_addr;
  logic                       o_bf_free_flag;
  logic [AWIDTH:0]            o_free_cnt;
  logic                       o_err;

  modport master (
    output i_gsm_wr_en, i_gsm_cell_addr, i_gsm_multicast, i_rel_valid, i_rel_addr, i_hmp_rd,
    input  o_rel_gnt, o_hmp_valid, o_hmp_addr, o_bf_free_flag, o_free_cnt, o_err
  );

  modport slave (
    input  i_gsm_wr_en, i_gsm_cell_addr, i_gsm_multicast, i_rel_valid, i_rel_addr, i_hmp_rd,
    output o_rel_gnt, o_hmp_valid, o_hmp_addr, o_bf_free_flag, o_free_cnt, o_err
  );
endinterface

// File: rtl/cell_refcnt_free_rr_arbiter.sv
// Round-robin arbiter: one-hot combinational grant, search starts at the registered pointer.
module rr_arbiter import cell_refcnt_free_pkg::*; #(
  parameter int N = 4,
  localparam int IW = (clogb(N) > 0) ? clogb(N) : 1
) (
  input  logic         clk,
  input  logic         clr,
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt,
  output logic         gnt_vld
);
  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] idx_s;
  logic          hit_s;

  // Walk the requests from ptr_q and grant the first one found; clr blocks all grants.
  always_comb begin
    gnt     = '0;
    gnt_vld = 1'b0;
    ptr_d   = ptr_q;
    idx_s   = '0;
    hit_s   = 1'b0;
    for (int i = 0; i < N; i++) begin
      idx_s        = IW'((int'(ptr_q) + i) % N);
      hit_s        = req[idx_s] && !gnt_vld && !clr;
      gnt[idx_s]   = gnt[idx_s] | hit_s;
      ptr_d        = hit_s ? IW'((int'(idx_s) + 1) % N) : ptr_d;
      gnt_vld      = gnt_vld | hit_s;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
endmodule

// File: rtl/cell_refcnt_free.sv
// Per-cell multicast reference counter; cells whose count reaches zero are queued in a
// first-word-fall-through free-address FIFO for the allocator.
module cell_refcnt_free import cell_refcnt_free_pkg::*; #(
  parameter int MWIDTH = MWIDTH_DEF,
  parameter int AWIDTH = AWIDTH_DEF
) (
  input logic               clk,
  input logic               clr,
  cell_refcnt_free_if.slave bus
);
  localparam int RC_W = clogb(MWIDTH) + 1;
  localparam int DEP  = 2 ** AWIDTH;

  logic [RC_W-1:0]   rc_q  [DEP];
  logic [RC_W-1:0]   rc_d  [DEP];
  logic [AWIDTH-1:0] mem_q [DEP];
  logic [AWIDTH-1:0] mem_d [DEP];
  logic [AWIDTH-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AWIDTH:0]   fcnt_q, fcnt_d;
  logic              flag_q, flag_d, err_q, err_d;

  logic [MWIDTH-1:0] gnt_s;
  logic              gnt_vld_s;
  logic [AWIDTH-1:0] rel_addr_s;
  logic [RC_W-1:0]   rel_cnt_s, alloc_cnt_s;
  logic              collide_s, alloc_err_s, push_req_s, push_s, pop_s, empty_s, full_s;
  rel_op_e           rel_op_s;

  rr_arbiter #(.N(MWIDTH)) u_arb (
    .clk     (clk),
    .clr     (clr),
    .req     (bus.i_rel_valid),
    .gnt     (gnt_s),
    .gnt_vld (gnt_vld_s)
  );

  // Select the granted port's address (one-hot AND-OR mux).
  always_comb begin
    rel_addr_s = '0;
    for (int p = 0; p < MWIDTH; p++) begin
      rel_addr_s = rel_addr_s | (bus.i_rel_addr[p*AWIDTH +: AWIDTH] & {AWIDTH{gnt_s[p]}});
    end
  end

  assign rel_cnt_s   = rc_q[rel_addr_s];
  assign alloc_cnt_s = RC_W'(popcount(32'(bus.i_gsm_multicast)));

  // A same-address allocation wins, so the colliding release is dropped entirely.
  always_comb begin
    collide_s = bus.i_gsm_wr_en && gnt_vld_s && (bus.i_gsm_cell_addr == rel_addr_s);
    if (!gnt_vld_s || collide_s) begin
      rel_op_s = REL_NONE;
    end else if (rel_cnt_s == '0) begin
      rel_op_s = REL_ERR;
    end else if (rel_cnt_s == RC_W'(1)) begin
      rel_op_s = REL_FREE;
    end else begin
      rel_op_s = REL_DEC;
    end
  end

  assign empty_s    = (fcnt_q == '0);
  assign full_s     = (fcnt_q == (AWIDTH+1)'(DEP));
  assign push_req_s = (rel_op_s == REL_FREE);
  assign push_s     = push_req_s && !full_s;
  assign pop_s      = bus.i_hmp_rd && !empty_s;

  // Next-state for the refcount file, free FIFO and status flags.
  always_comb begin
    rc_d  = rc_q;
    mem_d = mem_q;
    case (rel_op_s)
      REL_DEC:  rc_d[rel_addr_s] = rel_cnt_s - RC_W'(1);
      REL_FREE: rc_d[rel_addr_s] = '0;
      default:  rc_d[rel_addr_s] = rel_cnt_s;
    endcase
    if (bus.i_gsm_wr_en) begin
      rc_d[bus.i_gsm_cell_addr] = alloc_cnt_s;
      alloc_err_s = (rc_q[bus.i_gsm_cell_addr] != '0) || (alloc_cnt_s == '0);
    end else begin
      alloc_err_s = 1'b0;
    end
    if (push_s) begin
      mem_d[wptr_q] = rel_addr_s;
    end else begin
      mem_d[wptr_q] = mem_q[wptr_q];
    end
    wptr_d = wptr_q + AWIDTH'(push_s);
    rptr_d = rptr_q + AWIDTH'(pop_s);
    fcnt_d = fcnt_q + (AWIDTH+1)'(push_s) - (AWIDTH+1)'(pop_s);
    flag_d = push_s;
    err_d  = err_q | alloc_err_s | collide_s | (rel_op_s == REL_ERR)
           | (push_req_s && full_s) | (bus.i_hmp_rd && empty_s);
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < DEP; i++) begin
        rc_q[i]  <= '0;
        mem_q[i] <= '0;
      end
      wptr_q <= '0;
      rptr_q <= '0;
      fcnt_q <= '0;
      flag_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      rc_q   <= rc_d;
      mem_q  <= mem_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      fcnt_q <= fcnt_d;
      flag_q <= flag_d;
      err_q  <= err_d;
    end
  end

  assign bus.o_rel_gnt      = gnt_s;
  assign bus.o_hmp_valid    = !empty_s;
  assign bus.o_hmp_addr     = mem_q[rptr_q];
  assign bus.o_bf_free_flag = flag_q;
  assign bus.o_free_cnt     = fcnt_q;
  assign bus.o_err          = err_q;
endmodule
